exec_unit: RTL and testbench
============================

# exec_unit

- Execute-stage sequencer that drives the 16-bit ALU from the core side.
- Accepts one decoded ALU instruction per handshake, reads both source registers from the register file, and presents operands and an opcode to the combinational ALU.
- Captures the ALU result, updates the architectural flags register, and issues a writeback request.
- Sits between the decode stage (upstream) and the register-file write port (downstream).

## Interface
Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register index width

Ports:
- clk  in  1  core clock, all state on rising edge
- reset_b  in  1  asynchronous, active-low reset
- req_valid  in  1  decode has an instruction
- req_ready  out  1  unit can accept (high only in IDLE)
- req_op  in  3  ALU opcode
- req_src1, req_src2  in  REG_AW  source register indices
- req_dst  in  REG_AW  destination register index
- rf_rd_addr1, rf_rd_addr2  out  REG_AW  register-file read addresses; data returns one cycle later
- rf_rd_data1, rf_rd_data2  in  DATA_W  register-file read data
- alu_operand1, alu_operand2  out  DATA_W  registered ALU operands
- alu_operation  out  3  registered ALU opcode
- alu_flags_in  out  3  current flags to ALU
- alu_result  in  DATA_W  ALU result (combinational)
- alu_carry  in  1  ALU carry-out (flags_out[0])
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback port accepts
- wb_addr  out  REG_AW  destination index
- wb_data  out  DATA_W  result
- flags  out  3  architectural flags: [0]=C, [1]=Z, [2]=N
- illegal_op  out  1  one-cycle pulse for a reserved opcode

## Operation
Opcodes:
- 000 ADD, 010 SUB, 011 AND, 100 NOT op1, 101 PASS op1, 110 PASS op2.
- 001 and 111 are reserved.

State machine:
- IDLE: req_ready=1. On req_valid, latch op, src and dst; drive rf_rd_addr1/2; go to READ.
- READ: register rf_rd_data1/2 into alu_operand1/2 and the latched op into alu_operation; go to EXEC.
- EXEC, legal op: capture alu_result into wb_data and dst into wb_addr; update flags; set wb_valid; go to WB.
- EXEC, reserved op: pulse illegal_op; flags and wb unchanged; go to IDLE.
- WB: hold wb_valid, wb_addr and wb_data stable until wb_ready. On the wb_valid && wb_ready cycle, clear wb_valid and go to IDLE.

Flags:
- C is loaded from alu_carry only for ADD; all other ops keep C.
- Z = (alu_result == 0).
- N = alu_result[15].
- SUB does not produce a carry/borrow.

Boundary cases:
- req_valid outside IDLE is ignored; decode must hold the request.
- ADD 0xFFFF + 0x0001 gives result 0x0000, C=1, Z=1.
- req_src1 == req_src2 == req_dst is legal; the register value is read before writeback.
- reset_b asserted mid-operation aborts the instruction: no writeback, flags cleared.

Reset values:
- req_ready 1
- rf_rd_addr1/2 0; alu_operand1/2 0; alu_operation 000
- wb_valid 0; wb_addr 0; wb_data 0
- flags 000; illegal_op 0; state IDLE

## Timing
- Request accepted at edge T0 (req_valid && req_ready).
- READ during T0–T1, EXEC during T1–T2.
- wb_valid and the updated flags are visible after edge T2.
- Earliest return to IDLE is edge T3, when wb_ready is already high.
- Peak throughput is 1 instruction per 4 cycles. Each cycle wb_ready stays low adds one cycle.
- Reserved op: illegal_op is high for the cycle after edge T2; req_ready returns after edge T2.
- The ALU path is alu_operand registers → ALU → wb_data/flags capture, one full cycle.

## Configuration
- EXEC_UNIT_FLAGS_ZN_EN defined: Z and N are updated as described above.
- Undefined: flags[2:1] are held at 0 permanently. Only C is maintained, and the Z/N compare logic is not synthesized.

## Structure
- Shared package exec_pkg holds:
  - opcode constants (OP_ADD…OP_PASS2)
  - state encoding (IDLE, READ, EXEC, WB)
  - flag bit indices (FLAG_C, FLAG_Z, FLAG_N)
  - DATA_W/REG_AW defaults
- One sub-module, exec_flags_reg: the flags register with carry-load enable and Z/N generation, including the macro-gated logic.

## Test plan
- ADD r1=0x0003, r2=0x0004, dst r5, wb_ready=1 → wb_valid at T2+, wb_addr=5, wb_data=0x0007, flags=000, req_ready back at T3+.
- ADD 0xFFFF + 0x0001 → wb_data=0x0000, flags=011 (C=1, Z=1).
- SUB 0x0001 − 0x0002 with C previously 1 → wb_data=0xFFFF, flags=101 (C kept, N=1); with macro undefined, flags=001.
- wb_ready held low for 5 cycles → wb_valid, wb_addr and wb_data stable throughout, req_ready low, second req_valid ignored; completes on the first wb_ready cycle.
- Opcode 111 → illegal_op one-cycle pulse, no wb_valid, flags unchanged, req_ready high after T2.
- reset_b pulsed low during EXEC → all outputs at reset values, no writeback, next request processed normally.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, FSM states,
// flag bit positions and default widths.
package exec_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_RSV1  = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_NOT   = 3'b100;
  localparam logic [2:0] OP_PASS1 = 3'b101;
  localparam logic [2:0] OP_PASS2 = 3'b110;
  localparam logic [2:0] OP_RSV7  = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op != OP_RSV1) && (op != OP_RSV7);
  endfunction

endpackage

// File: rtl/exec_flags_reg.sv
// Architectural flags register: C loads only on ADD, Z/N follow the result.
// Z/N tracking exists only when EXEC_UNIT_FLAGS_ZN_EN is defined; otherwise they read 0.
module exec_flags_reg
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              update_i,
  input  logic              carry_load_i,
  input  logic              alu_carry_i,
  input  logic [DATA_W-1:0] result_i,
  output logic [2:0]        flags_o
);

  logic c_q, c_d;

  assign c_d = (update_i && carry_load_i) ? alu_carry_i : c_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) c_q <= 1'b0;
    else          c_q <= c_d;
  end

  assign flags_o[FLAG_C] = c_q;

`ifdef EXEC_UNIT_FLAGS_ZN_EN
  logic z_q, z_d, n_q, n_d;

  assign z_d = update_i ? (result_i == '0) : z_q;
  assign n_d = update_i ? result_i[DATA_W-1] : n_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign flags_o[FLAG_Z] = z_q;
  assign flags_o[FLAG_N] = n_q;
`else
  logic unused_result;
  assign unused_result   = ^result_i;
  assign flags_o[FLAG_Z] = 1'b0;
  assign flags_o[FLAG_N] = 1'b0;
`endif

endmodule

// File: rtl/exec_unit.sv
// Execute-stage sequencer: IDLE -> READ -> EXEC -> WB around an external ALU.
// Optional Z/N flag tracking is enabled by EXEC_UNIT_FLAGS_ZN_EN.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [REG_AW-1:0] req_src1,
  input  logic [REG_AW-1:0] req_src2,
  input  logic [REG_AW-1:0] req_dst,
  output logic [REG_AW-1:0] rf_rd_addr1,
  output logic [REG_AW-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  output logic [2:0]        alu_operation,
  output logic [2:0]        alu_flags_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              illegal_op
);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   dst_q;
  logic                req_ready_q;
  logic [REG_AW-1:0]   rf_rd_addr1_q, rf_rd_addr2_q;
  logic [DATA_W-1:0]   alu_operand1_q, alu_operand2_q;
  logic [2:0]          alu_operation_q;
  logic                wb_valid_q;
  logic [REG_AW-1:0]   wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                illegal_op_q;
  logic                flags_update, carry_load;

  // Flags capture in the same EXEC cycle as wb_data, from the registered opcode.
  assign flags_update = (state_q == EXEC) && op_is_legal(alu_operation_q);
  assign carry_load   = (alu_operation_q == OP_ADD);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q         <= IDLE;
      op_q            <= 3'b000;
      dst_q           <= '0;
      req_ready_q     <= 1'b1;
      rf_rd_addr1_q   <= '0;
      rf_rd_addr2_q   <= '0;
      alu_operand1_q  <= '0;
      alu_operand2_q  <= '0;
      alu_operation_q <= 3'b000;
      wb_valid_q      <= 1'b0;
      wb_addr_q       <= '0;
      wb_data_q       <= '0;
      illegal_op_q    <= 1'b0;
    end else begin
      illegal_op_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          op_q          <= req_op;
          dst_q         <= req_dst;
          rf_rd_addr1_q <= req_src1;
          rf_rd_addr2_q <= req_src2;
          req_ready_q   <= 1'b0;
          state_q       <= READ;
        end
        READ: begin
          alu_operand1_q  <= rf_rd_data1;
          alu_operand2_q  <= rf_rd_data2;
          alu_operation_q <= op_q;
          state_q         <= EXEC;
        end
        EXEC: if (op_is_legal(alu_operation_q)) begin
          wb_data_q  <= alu_result;
          wb_addr_q  <= dst_q;
          wb_valid_q <= 1'b1;
          state_q    <= WB;
        end else begin
          illegal_op_q <= 1'b1;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        WB: if (wb_ready) begin
          wb_valid_q  <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  exec_flags_reg #(.DATA_W(DATA_W)) u_flags (
    .clk          (clk),
    .reset_b      (reset_b),
    .update_i     (flags_update),
    .carry_load_i (carry_load),
    .alu_carry_i  (alu_carry),
    .result_i     (alu_result),
    .flags_o      (flags)
  );

  assign req_ready     = req_ready_q;
  assign rf_rd_addr1   = rf_rd_addr1_q;
  assign rf_rd_addr2   = rf_rd_addr2_q;
  assign alu_operand1  = alu_operand1_q;
  assign alu_operand2  = alu_operand2_q;
  assign alu_operation = alu_operation_q;
  assign alu_flags_in  = flags;
  assign wb_valid      = wb_valid_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign illegal_op    = illegal_op_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit with a register-file and ALU model.
// Expected writebacks are queued at issue time and popped when wb_valid appears.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_src1, req_src2, req_dst;
  logic [AW-1:0] rf_rd_addr1, rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2;
  logic [DW-1:0] alu_operand1, alu_operand2;
  logic [2:0]    alu_operation, alu_flags_in;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [2:0]    flags;
  logic          illegal_op;

  always #5 clk = ~clk;

  exec_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_flags_in(alu_flags_in),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .illegal_op(illegal_op)
  );

  // Register file: read data follows the registered read address.
  logic [DW-1:0] regs [8];
  assign rf_rd_data1 = regs[rf_rd_addr1];
  assign rf_rd_data2 = regs[rf_rd_addr2];

  // Combinational ALU.
  logic [DW:0] sum;
  always_comb begin
    sum        = {1'b0, alu_operand1} + {1'b0, alu_operand2};
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_operation)
      OP_ADD:   begin alu_result = sum[DW-1:0]; alu_carry = sum[DW]; end
      OP_SUB:   alu_result = alu_operand1 - alu_operand2;
      OP_AND:   alu_result = alu_operand1 & alu_operand2;
      OP_NOT:   alu_result = ~alu_operand1;
      OP_PASS1: alu_result = alu_operand1;
      OP_PASS2: alu_result = alu_operand2;
      default:  alu_result = '0;
    endcase
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    flg;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] model_flags;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input logic [AW-1:0] d, input int stall);
    exp_t          e;
    logic [DW-1:0] a, b, r;
    logic          c, legal;
    a     = regs[s1];
    b     = regs[s2];
    legal = op_is_legal(op);
    c     = model_flags[FLAG_C];
    r     = '0;
    case (op)
      OP_ADD:   {c, r} = {1'b0, a} + {1'b0, b};
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_NOT:   r = ~a;
      OP_PASS1: r = a;
      OP_PASS2: r = b;
      default:  r = '0;
    endcase
    if (legal) begin
      e.flg         = model_flags;
      e.flg[FLAG_C] = c;
`ifdef EXEC_UNIT_FLAGS_ZN_EN
      e.flg[FLAG_Z] = (r == '0);
      e.flg[FLAG_N] = r[DW-1];
`endif
      e.addr = d;
      e.data = r;
      exp_q.push_back(e);
    end

    chk("req_ready_idle", req_ready, 1);
    wb_ready  = (stall == 0);
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2; req_dst = d;
    @(posedge clk); #1;                 // T0
    req_valid = 1'b0;
    chk("req_ready_T0", req_ready, 0);
    chk("rd_addr1", rf_rd_addr1, s1);
    chk("rd_addr2", rf_rd_addr2, s2);
    @(posedge clk); #1;                 // T1
    chk("operand1", alu_operand1, a);
    chk("operand2", alu_operand2, b);
    chk("alu_operation", alu_operation, op);
    chk("wb_valid_T1", wb_valid, 0);
    @(posedge clk); #1;                 // T2
    if (!legal) begin
      chk("illegal_pulse", illegal_op, 1);
      chk("illegal_no_wb", wb_valid, 0);
      chk("illegal_flags", flags, model_flags);
      chk("illegal_ready", req_ready, 1);
      @(posedge clk); #1;
      chk("illegal_pulse_end", illegal_op, 0);
      chk("illegal_no_wb_after", wb_valid, 0);
      $display("txn op=%b src=%0d,%0d dst=%0d illegal flags=%b", op, s1, s2, d, flags);
      return;
    end
    e = exp_q.pop_front();
    model_flags = e.flg;
    chk("wb_valid_T2", wb_valid, 1);
    chk("wb_addr", wb_addr, e.addr);
    chk("wb_data", wb_data, e.data);
    chk("flags", flags, e.flg);
    chk("alu_flags_in", alu_flags_in, e.flg);
    chk("req_ready_WB", req_ready, 0);
    for (int k = 0; k < stall; k++) begin
      if (k == 0) begin
        req_valid = 1'b1; req_op = OP_ADD;
        req_src1 = s1 ^ 3'b111; req_src2 = s2 ^ 3'b111; req_dst = d ^ 3'b111;
      end
      @(posedge clk); #1;
      chk("stall_wb_valid", wb_valid, 1);
      chk("stall_wb_addr", wb_addr, e.addr);
      chk("stall_wb_data", wb_data, e.data);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rd_addr1", rf_rd_addr1, s1);
    end
    req_valid = 1'b0;
    wb_ready  = 1'b1;
    @(posedge clk); #1;                 // handshake edge
    regs[e.addr] = e.data;
    chk("wb_valid_done", wb_valid, 0);
    chk("req_ready_done", req_ready, 1);
    $display("txn op=%b src=%0d,%0d dst=%0d stall=%0d wb_data=%h flags=%b",
             op, s1, s2, d, stall, e.data, e.flg);
  endtask

  initial begin
    reset_b   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_src1  = '0;
    req_src2  = '0;
    req_dst   = '0;
    wb_ready  = 1'b1;
    model_flags = 3'b000;
    regs[0] = 16'h0000; regs[1] = 16'h0003; regs[2] = 16'h0004; regs[3] = 16'hFFFF;
    regs[4] = 16'h0001; regs[5] = 16'h0000; regs[6] = 16'h0002; regs[7] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_flags", flags, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_alu_op", alu_operation, 0);
    chk("rst_operand1", alu_operand1, 0);
    chk("rst_rd_addr1", rf_rd_addr1, 0);
    reset_b = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 3'd1, 3'd2, 3'd5, 0);   // 3 + 4 = 7
    issue(OP_ADD, 3'd3, 3'd4, 3'd7, 0);   // 0xFFFF + 1 -> 0, C=1
    issue(OP_SUB, 3'd4, 3'd6, 3'd0, 0);   // 1 - 2 = 0xFFFF, C kept
    issue(OP_AND, 3'd3, 3'd1, 3'd5, 5);   // stalled writeback
    issue(OP_RSV7, 3'd1, 3'd2, 3'd4, 0);  // reserved opcode

    // Abort an instruction by reset while it is in EXEC.
    chk("pre_abort_ready", req_ready, 1);
    req_valid = 1'b1; req_op = OP_ADD; req_src1 = 3'd1; req_src2 = 3'd2; req_dst = 3'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b0;
    #2;
    chk("abort_wb_valid", wb_valid, 0);
    chk("abort_flags", flags, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_operand1", alu_operand1, 0);
    chk("abort_wb_data", wb_data, 0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    model_flags = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_no_wb", wb_valid, 0);
    end
    $display("txn op=%b src=1,2 dst=3 aborted by reset flags=%b", OP_ADD, flags);

    issue(OP_ADD, 3'd6, 3'd6, 3'd6, 0);   // same src/dst register
    issue(OP_NOT, 3'd1, 3'd0, 3'd2, 0);   // ~3 = 0xFFFC
    issue(OP_PASS2, 3'd0, 3'd6, 3'd1, 0); // pass r6 (now 4)

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
